ofs_fim_mmio_cpl_gen: RTL and testbench



---
 rtl/ofs_fim_mmio_cpl_gen_pkg.sv | 109 ++++++++++
 rtl/ofs_fim_mmio_cpl_gen.sv | 186 ++++++++++++++++++
 tb/tb_ofs_fim_mmio_cpl_gen.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_mmio_cpl_gen_pkg.sv
// PCIe TLP header layouts and completion helpers shared by the MMIO responder.
// Header structs are 128-bit, DW0 in the most significant bits.
package ofs_fim_mmio_cpl_gen_pkg;

    localparam logic [7:0] PCIE_FMTTYPE_MRD32 = 8'h00;
    localparam logic [7:0] PCIE_FMTTYPE_MRD64 = 8'h20;
    localparam logic [7:0] PCIE_FMTTYPE_MWR32 = 8'h40;
    localparam logic [7:0] PCIE_FMTTYPE_MWR64 = 8'h60;
    localparam logic [7:0] PCIE_FMTTYPE_CPL   = 8'h0A;
    localparam logic [7:0] PCIE_FMTTYPE_CPLD  = 8'h4A;

    localparam logic [2:0] PCIE_CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] PCIE_CPL_STATUS_UR = 3'b001;
    localparam logic [2:0] PCIE_CPL_STATUS_CA = 3'b100;

    typedef struct packed {
        logic [7:0] fmttype;
        logic       rsvd0;
        logic [2:0] tc;
        logic       rsvd1;
        logic       attr2;
        logic       rsvd2;
        logic       th;
        logic       td;
        logic       ep;
        logic [1:0] attr;
        logic [1:0] at;
        logic [9:0] length;
    } t_tlp_hdr_dw0;

    typedef struct packed {
        t_tlp_hdr_dw0 dw0;
        logic [15:0]  requester_id;
        logic [7:0]   tag;
        logic [3:0]   last_be;
        logic [3:0]   first_be;
        logic [31:0]  addr;
        logic [31:0]  lsb_addr;
    } t_tlp_mem_req_hdr;

    typedef struct packed {
        t_tlp_hdr_dw0 dw0;
        logic [15:0]  completer_id;
        logic [2:0]   status;
        logic         bcm;
        logic [11:0]  byte_count;
        logic [15:0]  requester_id;
        logic [7:0]   tag;
        logic         rsvd0;
        logic [6:0]   lower_addr;
        logic [31:0]  rsvd1;
    } t_tlp_cpl_hdr;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CPL_SEND
    } t_cpl_gen_state;

    function automatic logic [1:0] func_be_lowest(input logic [3:0] be);
        if (be[0])      return 2'd0;
        else if (be[1]) return 2'd1;
        else if (be[2]) return 2'd2;
        else if (be[3]) return 2'd3;
        else            return 2'd0;
    endfunction

    function automatic logic [1:0] func_be_highest(input logic [3:0] be);
        if (be[3])      return 2'd3;
        else if (be[2]) return 2'd2;
        else if (be[1]) return 2'd1;
        else            return 2'd0;
    endfunction

    // Only lengths 1 and 2 reach a successful completion, so no other case is handled.
    function automatic logic [11:0] func_cpl_byte_count(
        input logic [9:0] length,
        input logic [3:0] first_be,
        input logic [3:0] last_be
    );
        logic [11:0] fo;
        logic [11:0] fhi;
        logic [11:0] lhi;
        fo  = {10'd0, func_be_lowest(first_be)};
        fhi = {10'd0, func_be_highest(first_be)};
        lhi = {10'd0, func_be_highest(last_be)};
        if (length == 10'd1) begin
            if (first_be == 4'h0) return 12'd1;
            return fhi - fo + 12'd1;
        end
        return 12'd8 - fo - (12'd3 - lhi);
    endfunction

    function automatic logic [6:0] func_cpl_lower_addr(
        input logic [6:0] addr,
        input logic [3:0] first_be
    );
        return {addr[6:2], func_be_lowest(first_be)};
    endfunction

    function automatic logic func_is_posted(input logic [7:0] fmttype);
        return (fmttype == PCIE_FMTTYPE_MWR32) ||
               (fmttype == PCIE_FMTTYPE_MWR64) ||
               (fmttype[7:3] == 5'b00110) ||
               (fmttype[7:3] == 5'b01110);
    endfunction

endpackage

// File: rtl/ofs_fim_mmio_cpl_gen.sv
// MMIO read responder: accepts one request header at a time, reads the CSR space
// and returns a single-beat CplD, or a Cpl with UR/CA status.
module ofs_fim_mmio_cpl_gen
    import ofs_fim_mmio_cpl_gen_pkg::*;
#(
    parameter int CSR_ADDR_W     = 20,
    parameter int TIMEOUT_CYCLES = 512,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [127:0]          rx_hdr,
    input  logic [15:0]           completer_id,
    output logic                  csr_rd,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    input  logic [63:0]           csr_rd_data,
    input  logic                  csr_rd_valid,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [127:0]          tx_hdr,
    output logic [63:0]           tx_data,
    output logic [CNT_W-1:0]      stat_ur_cnt,
    output logic [CNT_W-1:0]      stat_ca_cnt,
    output logic [CNT_W-1:0]      stat_drop_cnt,
    output logic                  busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    t_cpl_gen_state   state_q, state_d;
    t_tlp_mem_req_hdr req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    t_tlp_cpl_hdr     tx_hdr_q, tx_hdr_d;
    logic [63:0]      tx_data_q, tx_data_d;
    logic [CNT_W-1:0] ur_cnt_q, ur_cnt_d;
    logic [CNT_W-1:0] ca_cnt_q, ca_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    t_tlp_mem_req_hdr rx_req;
    logic [31:0]      rx_addr;
    logic             rx_is_mrd;
    logic             rx_supported;
    logic [63:0]      rd_data_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic t_tlp_cpl_hdr build_cpl_hdr(
        input t_tlp_mem_req_hdr req,
        input logic [15:0]      cid,
        input logic [2:0]       status,
        input logic [31:0]      addr
    );
        t_tlp_cpl_hdr h;
        h                = '0;
        h.dw0.tc         = req.dw0.tc;
        h.dw0.attr       = req.dw0.attr;
        h.dw0.attr2      = req.dw0.attr2;
        h.completer_id   = cid;
        h.status         = status;
        h.requester_id   = req.requester_id;
        h.tag            = req.tag;
        if (status == PCIE_CPL_STATUS_SC) begin
            h.dw0.fmttype = PCIE_FMTTYPE_CPLD;
            h.dw0.length  = req.dw0.length;
            h.byte_count  = func_cpl_byte_count(req.dw0.length, req.first_be, req.last_be);
            h.lower_addr  = func_cpl_lower_addr(addr[6:0], req.first_be);
        end else begin
            h.dw0.fmttype = PCIE_FMTTYPE_CPL;
            h.dw0.length  = 10'd0;
            h.byte_count  = 12'd4;
            h.lower_addr  = 7'd0;
        end
        return h;
    endfunction

    // 64-bit requests carry the low address dword in lsb_addr; only 32 bits matter here.
    assign rx_req       = t_tlp_mem_req_hdr'(rx_hdr);
    assign rx_addr      = rx_req.dw0.fmttype[5] ? rx_req.lsb_addr : rx_req.addr;
    assign rx_is_mrd    = (rx_req.dw0.fmttype == PCIE_FMTTYPE_MRD32) ||
                          (rx_req.dw0.fmttype == PCIE_FMTTYPE_MRD64);
    assign rx_supported = rx_is_mrd &&
                          ((rx_req.dw0.length == 10'd1) ||
                           ((rx_req.dw0.length == 10'd2) && !rx_addr[2]));

    assign rd_data_sel = (req_q.dw0.length == 10'd2) ? csr_rd_data :
                         {32'h0, addr_q[2] ? csr_rd_data[63:32] : csr_rd_data[31:0]};

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        tmo_d      = tmo_q;
        tx_hdr_d   = tx_hdr_q;
        tx_data_d  = tx_data_q;
        ur_cnt_d   = ur_cnt_q;
        ca_cnt_d   = ca_cnt_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    req_d  = rx_req;
                    addr_d = rx_addr;
                    if (func_is_posted(rx_req.dw0.fmttype)) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end else if (rx_supported) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        tx_hdr_d  = build_cpl_hdr(rx_req, completer_id, PCIE_CPL_STATUS_UR, rx_addr);
                        tx_data_d = 64'h0;
                        state_d   = ST_CPL_SEND;
                    end
                end
            end
            ST_RD_REQ: begin
                tmo_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Data arriving on the expiry cycle still produces a normal completion.
                if (csr_rd_valid) begin
                    tx_hdr_d  = build_cpl_hdr(req_q, completer_id, PCIE_CPL_STATUS_SC, addr_q);
                    tx_data_d = rd_data_sel;
                    state_d   = ST_CPL_SEND;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tx_hdr_d  = build_cpl_hdr(req_q, completer_id, PCIE_CPL_STATUS_CA, addr_q);
                    tx_data_d = 64'h0;
                    ca_cnt_d  = sat_inc(ca_cnt_q);
                    state_d   = ST_CPL_SEND;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CPL_SEND: begin
                if (tx_ready) begin
                    if (tx_hdr_q.status == PCIE_CPL_STATUS_UR) ur_cnt_d = sat_inc(ur_cnt_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            addr_q     <= '0;
            tmo_q      <= '0;
            tx_hdr_q   <= '0;
            tx_data_q  <= '0;
            ur_cnt_q   <= '0;
            ca_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            tmo_q      <= tmo_d;
            tx_hdr_q   <= tx_hdr_d;
            tx_data_q  <= tx_data_d;
            ur_cnt_q   <= ur_cnt_d;
            ca_cnt_q   <= ca_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rx_ready      = (state_q == ST_IDLE);
    assign csr_rd        = (state_q == ST_RD_REQ);
    assign csr_addr      = {addr_q[CSR_ADDR_W-1:3], 3'b000};
    assign tx_valid      = (state_q == ST_CPL_SEND);
    assign tx_hdr        = tx_hdr_q;
    assign tx_data       = tx_data_q;
    assign stat_ur_cnt   = ur_cnt_q;
    assign stat_ca_cnt   = ca_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
    assign busy          = (state_q != ST_IDLE);

    logic unused_sink;
    assign unused_sink = ^{req_q, addr_q, rx_req};

endmodule

// File: tb/tb_ofs_fim_mmio_cpl_gen.sv
// Scoreboard bench for the MMIO completion generator: expected completions are
// queued as requests are issued and popped when tx_valid is observed.
module tb_ofs_fim_mmio_cpl_gen;

    localparam int          CSR_ADDR_W = 20;
    localparam int          TMO        = 8;
    localparam int          CNT_W      = 16;
    localparam logic [15:0] CID        = 16'hBEEF;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [127:0]          rx_hdr;
    logic [15:0]           completer_id;
    logic                  csr_rd;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [63:0]           csr_rd_data;
    logic                  csr_rd_valid;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [127:0]          tx_hdr;
    logic [63:0]           tx_data;
    logic [CNT_W-1:0]      stat_ur_cnt;
    logic [CNT_W-1:0]      stat_ca_cnt;
    logic [CNT_W-1:0]      stat_drop_cnt;
    logic                  busy;

    ofs_fim_mmio_cpl_gen #(
        .CSR_ADDR_W    (CSR_ADDR_W),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_hdr       (rx_hdr),
        .completer_id (completer_id),
        .csr_rd       (csr_rd),
        .csr_addr     (csr_addr),
        .csr_rd_data  (csr_rd_data),
        .csr_rd_valid (csr_rd_valid),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_hdr       (tx_hdr),
        .tx_data      (tx_data),
        .stat_ur_cnt  (stat_ur_cnt),
        .stat_ca_cnt  (stat_ca_cnt),
        .stat_drop_cnt(stat_drop_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] hdr;
        logic [63:0]  data;
        int           lat;
    } exp_t;

    typedef struct {
        logic [127:0]          req;
        logic [63:0]           resp;
        int                    csr_lat;
        logic [CSR_ADDR_W-1:0] caddr;
        logic [127:0]          cpl;
        logic [63:0]           data;
    } rd_case_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          csr_rd_seen = 0;
    bit          csr_en = 1'b1;
    int          csr_lat = 2;
    logic [63:0] csr_resp = 64'h0;

    function automatic logic [127:0] mk_req(
        input logic [7:0] ft, input logic [2:0] tc, input logic [1:0] attr,
        input logic [9:0] len, input logic [15:0] rid, input logic [7:0] tag,
        input logic [3:0] lbe, input logic [3:0] fbe,
        input logic [31:0] a_hi, input logic [31:0] a_lo);
        return {ft, 1'b0, tc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, attr, 2'b00, len,
                rid, tag, lbe, fbe, a_hi, a_lo};
    endfunction

    function automatic logic [127:0] mk_cpl(
        input logic [7:0] ft, input logic [2:0] tc, input logic [1:0] attr,
        input logic [9:0] len, input logic [2:0] status, input logic [11:0] bytes,
        input logic [15:0] rid, input logic [7:0] tag, input logic [6:0] low);
        return {ft, 1'b0, tc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, attr, 2'b00, len,
                CID, status, 1'b0, bytes, rid, tag, 1'b0, low, 32'h0};
    endfunction

    // CSR responder: returns csr_resp csr_lat cycles after the strobe cycle.
    initial begin
        csr_rd_valid = 1'b0;
        csr_rd_data  = 64'h0;
        forever begin
            @(negedge clk);
            if (csr_rd === 1'b1 && csr_en) begin
                repeat (csr_lat) @(posedge clk);
                #1;
                csr_rd_valid = 1'b1;
                csr_rd_data  = csr_resp;
                @(posedge clk);
                #1;
                csr_rd_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) if (csr_rd === 1'b1) csr_rd_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [127:0] h);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_hdr   = h;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int first, output int lat, output bit seen);
        seen = 1'b0;
        lat  = -1;
        for (int c = first; c < first + 40; c++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rx_ready, csr_rd, tx_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: rx_ready/csr_rd/tx_valid/busy=%b want 1000",
                     {rx_ready, csr_rd, tx_valid, busy});
        end
        checks++;
        if ({tx_hdr, tx_data} !== 192'h0) begin
            errors++;
            $display("FAIL reset_tx: hdr=%h data=%h want 0", tx_hdr, tx_data);
        end
        checks++;
        if ({stat_ur_cnt, stat_ca_cnt, stat_drop_cnt} !== 48'h0) begin
            errors++;
            $display("FAIL reset_cnt: ur=%0d ca=%0d drop=%0d want 0",
                     stat_ur_cnt, stat_ca_cnt, stat_drop_cnt);
        end
        $display("reset: rx_ready=%b busy=%b", rx_ready, busy);
        rst = 1'b0;
    endtask

    task automatic test_mrd();
        rd_case_t cs[5];
        exp_t     e;
        int       lat;
        bit       seen;
        cs[0] = '{mk_req(8'h00, 3'd0, 2'b00, 10'd1, 16'h0100, 8'h12, 4'h0, 4'hF, 32'h0000_1004, 32'hDEAD_0000),
                  64'hAABBCCDD_11223344, 2, 20'h01000,
                  mk_cpl(8'h4A, 3'd0, 2'b00, 10'd1, 3'b000, 12'd4, 16'h0100, 8'h12, 7'h04),
                  64'h00000000_AABBCCDD};
        cs[1] = '{mk_req(8'h20, 3'd2, 2'b01, 10'd2, 16'h0200, 8'h34, 4'hF, 4'hF, 32'h0000_0000, 32'h0000_2008),
                  64'h01234567_89ABCDEF, 1, 20'h02008,
                  mk_cpl(8'h4A, 3'd2, 2'b01, 10'd2, 3'b000, 12'd8, 16'h0200, 8'h34, 7'h08),
                  64'h01234567_89ABCDEF};
        cs[2] = '{mk_req(8'h00, 3'd0, 2'b00, 10'd1, 16'h0300, 8'h56, 4'h0, 4'h6, 32'h0000_0044, 32'h0),
                  64'h55667788_99AABBCC, 3, 20'h00040,
                  mk_cpl(8'h4A, 3'd0, 2'b00, 10'd1, 3'b000, 12'd2, 16'h0300, 8'h56, 7'h45),
                  64'h00000000_55667788};
        cs[3] = '{mk_req(8'h00, 3'd0, 2'b00, 10'd1, 16'h0300, 8'h78, 4'h0, 4'h0, 32'h0000_0030, 32'h0),
                  64'hCAFEF00D_DEADBEEF, 2, 20'h00030,
                  mk_cpl(8'h4A, 3'd0, 2'b00, 10'd1, 3'b000, 12'd1, 16'h0300, 8'h78, 7'h30),
                  64'h00000000_DEADBEEF};
        cs[4] = '{mk_req(8'h20, 3'd5, 2'b10, 10'd2, 16'h0500, 8'h9C, 4'h7, 4'hE, 32'h0000_0001, 32'h0012_3450),
                  64'hFEDCBA98_76543210, 2, 20'h23450,
                  mk_cpl(8'h4A, 3'd5, 2'b10, 10'd2, 3'b000, 12'd6, 16'h0500, 8'h9C, 7'h51),
                  64'hFEDCBA98_76543210};
        for (int i = 0; i < 5; i++) begin
            csr_resp = cs[i].resp;
            csr_lat  = cs[i].csr_lat;
            sb.push_back('{cs[i].cpl, cs[i].data, cs[i].csr_lat + 2});
            issue(cs[i].req);
            @(negedge clk);
            checks++;
            if (csr_rd !== 1'b1 || csr_addr !== cs[i].caddr) begin
                errors++;
                $display("FAIL mrd%0d_csr: csr_rd=%b addr=%h want 1 %h", i, csr_rd, csr_addr, cs[i].caddr);
            end
            wait_tx(2, lat, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL mrd%0d_tx_timeout: no tx_valid, want completion", i);
            end else begin
                e = sb.pop_front();
                checks++;
                if (lat !== e.lat) begin
                    errors++;
                    $display("FAIL mrd%0d_latency: got N+%0d want N+%0d", i, lat, e.lat);
                end
                checks++;
                if (tx_hdr !== e.hdr || tx_data !== e.data) begin
                    errors++;
                    $display("FAIL mrd%0d_cpl: hdr=%h data=%h want %h %h", i, tx_hdr, tx_data, e.hdr, e.data);
                end
            end
            $display("mrd%0d: csr_addr=%h lat=%0d hdr=%h data=%h", i, cs[i].caddr, lat, tx_hdr, tx_data);
        end
    endtask

    task automatic test_ur();
        logic [127:0] reqs[3];
        logic [127:0] cpls[3];
        exp_t         e;
        int           lat;
        int           rd_before;
        bit           seen;
        reqs[0] = mk_req(8'h00, 3'd0, 2'b00, 10'd4, 16'h0600, 8'hA1, 4'hF, 4'hF, 32'h0000_1000, 32'h0);
        reqs[1] = mk_req(8'h00, 3'd3, 2'b11, 10'd2, 16'h0601, 8'hA2, 4'hF, 4'hF, 32'h0000_1004, 32'h0);
        reqs[2] = mk_req(8'h01, 3'd0, 2'b00, 10'd1, 16'h0602, 8'hA3, 4'h0, 4'hF, 32'h0000_1000, 32'h0);
        cpls[0] = mk_cpl(8'h0A, 3'd0, 2'b00, 10'd0, 3'b001, 12'd4, 16'h0600, 8'hA1, 7'h0);
        cpls[1] = mk_cpl(8'h0A, 3'd3, 2'b11, 10'd0, 3'b001, 12'd4, 16'h0601, 8'hA2, 7'h0);
        cpls[2] = mk_cpl(8'h0A, 3'd0, 2'b00, 10'd0, 3'b001, 12'd4, 16'h0602, 8'hA3, 7'h0);
        for (int i = 0; i < 3; i++) begin
            rd_before = csr_rd_seen;
            sb.push_back('{cpls[i], 64'h0, 1});
            issue(reqs[i]);
            wait_tx(1, lat, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL ur%0d_tx_timeout: no tx_valid, want UR completion", i);
            end else begin
                e = sb.pop_front();
                checks++;
                if (lat !== e.lat || tx_hdr !== e.hdr || tx_data !== e.data) begin
                    errors++;
                    $display("FAIL ur%0d_cpl: lat=%0d hdr=%h data=%h want %0d %h %h",
                             i, lat, tx_hdr, tx_data, e.lat, e.hdr, e.data);
                end
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (stat_ur_cnt !== CNT_W'(i + 1) || csr_rd_seen != rd_before || busy !== 1'b0) begin
                errors++;
                $display("FAIL ur%0d_after: ur_cnt=%0d csr_rd_cycles=%0d busy=%b want %0d 0 0",
                         i, stat_ur_cnt, csr_rd_seen - rd_before, busy, i + 1);
            end
            $display("ur%0d: lat=%0d ur_cnt=%0d", i, lat, stat_ur_cnt);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   lat;
        int   hits;
        bit   seen;
        csr_en = 1'b0;
        sb.push_back('{mk_cpl(8'h0A, 3'd1, 2'b10, 10'd0, 3'b100, 12'd4, 16'h0400, 8'h9A, 7'h0),
                       64'h0, TMO + 2});
        issue(mk_req(8'h00, 3'd1, 2'b10, 10'd1, 16'h0400, 8'h9A, 4'h0, 4'hF, 32'h0000_0100, 32'h0));
        @(negedge clk);
        wait_tx(2, lat, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_tx: no tx_valid, want CA completion");
        end else begin
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || tx_hdr !== e.hdr || tx_data !== e.data) begin
                errors++;
                $display("FAIL timeout_cpl: lat=%0d hdr=%h data=%h want %0d %h %h",
                         lat, tx_hdr, tx_data, e.lat, e.hdr, e.data);
            end
            checks++;
            if (stat_ca_cnt !== CNT_W'(1)) begin
                errors++;
                $display("FAIL timeout_ca_cnt: got %0d want 1", stat_ca_cnt);
            end
        end
        $display("timeout: lat=%0d ca_cnt=%0d", lat, stat_ca_cnt);
        @(posedge clk);
        #1;
        csr_rd_valid = 1'b1;
        csr_rd_data  = 64'h5A5A5A5A_A5A5A5A5;
        @(posedge clk);
        #1;
        csr_rd_valid = 1'b0;
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || busy !== 1'b0) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL late_valid: tx_valid/busy high in %0d cycles, want 0", hits);
        end
        csr_en   = 1'b1;
        csr_lat  = 2;
        csr_resp = 64'h11112222_33334444;
        sb.push_back('{mk_cpl(8'h4A, 3'd0, 2'b00, 10'd1, 3'b000, 12'd4, 16'h0400, 8'h9B, 7'h08),
                       64'h00000000_33334444, 4});
        issue(mk_req(8'h00, 3'd0, 2'b00, 10'd1, 16'h0400, 8'h9B, 4'h0, 4'hF, 32'h0000_0108, 32'h0));
        wait_tx(1, lat, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL after_timeout_tx: no tx_valid, want completion");
        end else begin
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || tx_hdr !== e.hdr || tx_data !== e.data || stat_ca_cnt !== CNT_W'(1)) begin
                errors++;
                $display("FAIL after_timeout_cpl: lat=%0d hdr=%h data=%h ca=%0d want %0d %h %h 1",
                         lat, tx_hdr, tx_data, stat_ca_cnt, e.lat, e.hdr, e.data);
            end
        end
        $display("after_timeout: lat=%0d data=%h", lat, tx_data);
    endtask

    task automatic test_posted();
        logic [7:0] fts[3];
        int         bad;
        int         rd_before;
        fts[0] = 8'h60;
        fts[1] = 8'h34;
        fts[2] = 8'h72;
        for (int i = 0; i < 3; i++) begin
            rd_before = csr_rd_seen;
            issue(mk_req(fts[i], 3'd0, 2'b00, 10'd1, 16'h0700, 8'hE0, 4'h0, 4'hF, 32'h0, 32'h0000_0800));
            bad = 0;
            repeat (6) begin
                @(negedge clk);
                if (tx_valid !== 1'b0 || rx_ready !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0 || csr_rd_seen != rd_before || stat_drop_cnt !== CNT_W'(i + 1)) begin
                errors++;
                $display("FAIL posted%0d: bad_cycles=%0d csr_rd=%0d drop=%0d want 0 0 %0d",
                         i, bad, csr_rd_seen - rd_before, stat_drop_cnt, i + 1);
            end
            $display("posted%0d: fmttype=%h drop_cnt=%0d", i, fts[i], stat_drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   seen;
        csr_lat  = 2;
        csr_resp = 64'h89ABCDEF_01234567;
        sb.push_back('{mk_cpl(8'h4A, 3'd0, 2'b00, 10'd1, 3'b000, 12'd2, 16'h0800, 8'hB0, 7'h0E),
                       64'h00000000_89ABCDEF, 4});
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_hdr   = mk_req(8'h40, 3'd0, 2'b00, 10'd1, 16'h0800, 8'hAF, 4'h0, 4'hF, 32'h0000_2000, 32'h0);
        @(posedge clk);
        #1;
        rx_hdr   = mk_req(8'h00, 3'd0, 2'b00, 10'd1, 16'h0800, 8'hB0, 4'h0, 4'hC, 32'h0000_200C, 32'h0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (csr_rd !== 1'b1 || csr_addr !== 20'h02008 || stat_drop_cnt !== CNT_W'(4)) begin
            errors++;
            $display("FAIL b2b_accept: csr_rd=%b addr=%h drop=%0d want 1 02008 4",
                     csr_rd, csr_addr, stat_drop_cnt);
        end
        wait_tx(2, lat, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_tx: no tx_valid, want completion");
        end else begin
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || tx_hdr !== e.hdr || tx_data !== e.data) begin
                errors++;
                $display("FAIL b2b_cpl: lat=%0d hdr=%h data=%h want %0d %h %h",
                         lat, tx_hdr, tx_data, e.lat, e.hdr, e.data);
            end
        end
        $display("b2b: drop_cnt=%0d lat=%0d data=%h", stat_drop_cnt, lat, tx_data);
    endtask

    task automatic test_backpressure();
        exp_t         e;
        int           lat;
        bit           seen;
        logic [127:0] h0;
        logic [63:0]  d0;
        csr_lat  = 1;
        csr_resp = 64'h0F0E0D0C_0B0A0908;
        sb.push_back('{mk_cpl(8'h4A, 3'd0, 2'b00, 10'd2, 3'b000, 12'd6, 16'h0900, 8'hC0, 7'h00),
                       64'h0F0E0D0C_0B0A0908, 3});
        @(negedge clk);
        tx_ready = 1'b0;
        issue(mk_req(8'h20, 3'd0, 2'b00, 10'd2, 16'h0900, 8'hC0, 4'h3, 4'hF, 32'h0, 32'h0000_3000));
        wait_tx(1, lat, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_tx: no tx_valid, want completion");
        end else begin
            h0 = tx_hdr;
            d0 = tx_data;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                checks++;
                if (tx_valid !== 1'b1 || tx_hdr !== h0 || tx_data !== d0) begin
                    errors++;
                    $display("FAIL bp_stable%0d: valid=%b hdr=%h data=%h want 1 %h %h",
                             k, tx_valid, tx_hdr, tx_data, h0, d0);
                end
            end
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || tx_hdr !== e.hdr || tx_data !== e.data) begin
                errors++;
                $display("FAIL bp_cpl: lat=%0d hdr=%h data=%h want %0d %h %h",
                         lat, tx_hdr, tx_data, e.lat, e.hdr, e.data);
            end
        end
        tx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: tx_valid=%b rx_ready=%b want 0 1", tx_valid, rx_ready);
        end
        $display("backpressure: lat=%0d hdr=%h", lat, h0);
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        int   bad;
        bit   seen;
        csr_en = 1'b0;
        issue(mk_req(8'h00, 3'd0, 2'b00, 10'd1, 16'h0A00, 8'hCF, 4'h0, 4'hF, 32'h0000_4000, 32'h0));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || csr_rd !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait: busy=%b csr_rd=%b tx_valid=%b want 1 0 0", busy, csr_rd, tx_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: tx_valid=%b rx_ready=%b busy=%b want 0 1 0", tx_valid, rx_ready, busy);
        end
        checks++;
        if ({stat_ur_cnt, stat_ca_cnt, stat_drop_cnt} !== 48'h0) begin
            errors++;
            $display("FAIL abort_cnt: ur=%0d ca=%0d drop=%0d want 0", stat_ur_cnt, stat_ca_cnt, stat_drop_cnt);
        end
        bad = 0;
        repeat (TMO + 4) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_cpl: tx_valid high %0d cycles want 0", bad);
        end
        csr_en   = 1'b1;
        csr_lat  = 2;
        csr_resp = 64'h77778888_99990000;
        sb.push_back('{mk_cpl(8'h4A, 3'd0, 2'b00, 10'd1, 3'b000, 12'd1, 16'h0A00, 8'hD0, 7'h04),
                       64'h00000000_77778888, 4});
        issue(mk_req(8'h00, 3'd0, 2'b00, 10'd1, 16'h0A00, 8'hD0, 4'h0, 4'h1, 32'h0000_4004, 32'h0));
        wait_tx(1, lat, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_recover_tx: no tx_valid, want completion");
        end else begin
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || tx_hdr !== e.hdr || tx_data !== e.data) begin
                errors++;
                $display("FAIL abort_recover_cpl: lat=%0d hdr=%h data=%h want %0d %h %h",
                         lat, tx_hdr, tx_data, e.lat, e.hdr, e.data);
            end
        end
        $display("reset_abort: recovered lat=%0d data=%h", lat, tx_data);
    endtask

    initial begin
        rst          = 1'b1;
        rx_valid     = 1'b0;
        rx_hdr       = 128'h0;
        completer_id = CID;
        tx_ready     = 1'b1;
        test_reset();
        test_mrd();
        test_ur();
        test_timeout();
        test_posted();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected completions left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
